// File: rtl/exec_stage.sv
// Sequenced execute stage: READ operands, EXEC shift/ALU, WRITE result back to the register file.
// Optional macro EXEC_SAT_EN makes ADD saturate on signed overflow instead of wrapping.
module exec_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [1:0]    shift,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
  output logic [RW-1:0] reg_a,
  output logic [RW-1:0] reg_b,
  input  logic [DW-1:0] out_a,
  input  logic [DW-1:0] out_b,
  output logic          write,
  output logic [RW-1:0] reg_w,
  output logic [DW-1:0] data_in,
  output logic          busy,
  output logic          done,
  output logic [2:0]    status
);

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpCmp = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpMvn = 2'b11;

  state_e        state_q, state_d;
  logic [1:0]    op_q, shift_q;
  logic [RW-1:0] rd_q, rn_q, rm_q;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [2:0]    status_q;

  logic [DW-1:0] bs, sum, diff, result;
  logic          add_v, sub_v, v;

  // Shifter and ALU operate on the captured operands only.
  always_comb begin
    unique case (shift_q)
      2'b00:   bs = b_q;
      2'b01:   bs = {b_q[DW-2:0], 1'b0};
      2'b10:   bs = {1'b0, b_q[DW-1:1]};
      default: bs = {b_q[DW-1], b_q[DW-1:1]};
    endcase
    sum   = a_q + bs;
    diff  = a_q - bs;
    add_v = (a_q[DW-1] == bs[DW-1]) && (sum[DW-1] != a_q[DW-1]);
    sub_v = (a_q[DW-1] != bs[DW-1]) && (diff[DW-1] != a_q[DW-1]);
    result = '0;
    v      = 1'b0;
    unique case (op_q)
      OpAdd: begin
        result = sum;
        v      = add_v;
`ifdef EXEC_SAT_EN
        // Overflow only occurs with like-signed operands, so A's sign picks the rail.
        if (add_v) result = a_q[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
      end
      OpCmp: begin
        result = diff;
        v      = sub_v;
      end
      OpAnd:   result = a_q & bs;
      default: result = ~bs;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      shift_q  <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            shift_q <= shift;
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
          end
        end
        StRead: begin
          a_q <= out_a;
          b_q <= out_b;
        end
        StExec: begin
          c_q      <= result;
          status_q <= {(result == '0), result[DW-1], v};
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only; no path from start.
  always_comb begin
    reg_a   = '0;
    reg_b   = '0;
    write   = 1'b0;
    reg_w   = '0;
    data_in = '0;
    done    = 1'b0;
    busy    = (state_q != StIdle);
    status  = status_q;
    if (state_q == StRead) begin
      reg_a = rn_q;
      reg_b = rm_q;
    end
    if (state_q == StWrite) begin
      done    = 1'b1;
      write   = (op_q != OpCmp);
      reg_w   = rd_q;
      data_in = c_q;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: a register-file model, an arithmetic reference model,
// directed cases and randomized operations.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0, shift = '0;
  logic [2:0]  rd = '0, rn = '0, rm = '0;
  logic [2:0]  reg_a, reg_b, reg_w;
  logic [15:0] out_a, out_b, data_in;
  logic        write, busy, done;
  logic [2:0]  status;

  logic [15:0] rf [8];
  logic [15:0] ref_rf [8];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_idx = '0;
  logic [15:0] poke_val = '0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int issued = 0;

  typedef struct {
    logic        w;
    logic [2:0]  rw;
    logic [15:0] d;
    logic [2:0]  st;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  exec_stage #(.DW(16), .RW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
    .rd(rd), .rn(rn), .rm(rm), .reg_a(reg_a), .reg_b(reg_b),
    .out_a(out_a), .out_b(out_b), .write(write), .reg_w(reg_w),
    .data_in(data_in), .busy(busy), .done(done), .status(status)
  );

  assign out_a = rf[reg_a];
  assign out_b = rf[reg_b];

  // Register file: writes land on the negedge.
  always @(negedge clk) begin
    if (write) rf[reg_w] <= data_in;
    else if (poke_en) rf[poke_idx] <= poke_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [1:0] s, input logic [2:0] d,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t m;
    logic [15:0] bs, res;
    int sa, sb, r;
    logic v;
    case (s)
      2'd0: bs = b;
      2'd1: bs = b << 1;
      2'd2: bs = b >> 1;
      default: bs = 16'($signed(b) >>> 1);
    endcase
    sa = int'($signed(a));
    sb = int'($signed(bs));
    v = 1'b0;
    r = 0;
    case (o)
      2'd0: begin
        r = sa + sb;
        v = (r > 32767) || (r < -32768);
        res = r[15:0];
`ifdef EXEC_SAT_EN
        if (v) res = (r > 0) ? 16'h7fff : 16'h8000;
`endif
      end
      2'd1: begin
        r = sa - sb;
        v = (r > 32767) || (r < -32768);
        res = r[15:0];
      end
      2'd2: res = a & bs;
      default: res = ~bs;
    endcase
    m.w  = (o != 2'd1);
    m.rw = d;
    m.d  = res;
    m.st = {(res == 16'h0), res[15], v};
    return m;
  endfunction

  // Monitor: every WRITE cycle pops one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (write && !done) check("write_outside_done", 32'(write), 32'd0);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write", 32'(write), 32'(e.w));
          check("reg_w", 32'(reg_w), 32'(e.rw));
          check("data_in", 32'(data_in), 32'(e.d));
          check("status", 32'(status), 32'(e.st));
        end
      end
    end
  end

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_rf[idx] = val;
    @(negedge clk);
    #1 poke_en = 1'b0;
  endtask

  // mode 0: plain op; 1: extra start pulse during EXEC; 2: reset during EXEC (abort).
  task automatic do_op(input logic [1:0] o, input logic [1:0] s, input logic [2:0] d,
                       input logic [2:0] n, input logic [2:0] m, input int mode);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; shift = s; rd = d; rn = n; rm = m;
    @(posedge clk);
    #1 start = 1'b0;
    e = model(o, s, d, ref_rf[n], ref_rf[m]);
    if (mode != 2) begin
      exp_q.push_back(e);
      issued++;
      if (e.w) ref_rf[d] = e.d;
    end
    @(negedge clk);
    check("read_reg_a", 32'(reg_a), 32'(n));
    check("read_reg_b", 32'(reg_b), 32'(m));
    check("read_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (mode == 1) begin
      start = 1'b1; op = ~o; rd = ~d;
    end else if (mode == 2) begin
      reset = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    if (mode == 2) begin
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_status", 32'(status), 32'd0);
      check("abort_write", 32'(write), 32'd0);
    end else begin
      check("done_timing", 32'(done), 32'd1);
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'($urandom);
      ref_rf[i] = rf[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_regs", 32'({reg_a, reg_b, reg_w}), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    reset = 1'b0;
    @(posedge clk);

    set_reg(1, 16'h0005); set_reg(2, 16'h0003);
    do_op(2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 0);
    check("add_r3", 32'(rf[3]), 32'h0008);

    set_reg(1, 16'h0004); set_reg(2, 16'h0004);
    do_op(2'b01, 2'b00, 3'd5, 3'd1, 3'd2, 0);

    set_reg(1, 16'h7fff); set_reg(2, 16'h0001);
    do_op(2'b00, 2'b00, 3'd4, 3'd1, 3'd2, 0);
`ifdef EXEC_SAT_EN
    check("ovf_r4", 32'(rf[4]), 32'h7fff);
`else
    check("ovf_r4", 32'(rf[4]), 32'h8000);
`endif

    set_reg(2, 16'h8001);
    do_op(2'b11, 2'b10, 3'd5, 3'd0, 3'd2, 0);
    check("mvn_lsr", 32'(rf[5]), 32'hbfff);
    do_op(2'b11, 2'b11, 3'd6, 3'd0, 3'd2, 0);
    check("mvn_asr", 32'(rf[6]), 32'h3fff);
    do_op(2'b11, 2'b01, 3'd7, 3'd0, 3'd2, 0);
    check("mvn_lsl", 32'(rf[7]), 32'hfffd);

    do_op(2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 1);
    do_op(2'b10, 2'b00, 3'd0, 3'd1, 3'd2, 2);

    set_reg(1, 16'h0002);
    do_op(2'b00, 2'b00, 3'd1, 3'd1, 3'd1, 0);
    do_op(2'b00, 2'b00, 3'd1, 3'd1, 3'd1, 0);
    check("dep_r1", 32'(rf[1]), 32'h0008);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) set_reg(3'($urandom), 16'($urandom));
      do_op(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(issued));
    for (int i = 0; i < 8; i++) check("final_rf", 32'(rf[i]), 32'(ref_rf[i]));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
